usb_rx_bit_decoder: RTL and testbench



---
 rtl/usb_rx_bit_decoder_if.sv | 25 ++
 rtl/usb_rx_bit_decoder.sv | 238 +++++++++++++++++++++++
 tb/tb_usb_rx_bit_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_bit_decoder_if.sv
// Bus bundle between the USB RX bit decoder and its neighbours:
// line inputs plus enable on one side, decoded byte stream and status strobes on the other.
interface usb_rx_bit_decoder_if;
  logic       rx_enable;
  logic       d_plus_sync;
  logic       d_minus_sync;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_active;
  logic       eop;
  logic       stuff_err;
  logic       sync_err;

  // Driver side: the RX controller / line front end
  modport master (
    output rx_enable, d_plus_sync, d_minus_sync,
    input  rx_byte, rx_byte_valid, rx_active, eop, stuff_err, sync_err
  );

  // Decoder side
  modport slave (
    input  rx_enable, d_plus_sync, d_minus_sync,
    output rx_byte, rx_byte_valid, rx_active, eop, stuff_err, sync_err
  );
endinterface

// File: rtl/usb_rx_bit_decoder.sv
// USB full-speed receive bit layer: recovers bit timing from the synchronized
// D+/D- lines, NRZI-decodes, drops stuffed bits, assembles bytes LSB-first and
// detects end-of-packet.
// Optional macro RX_SYNC_STRIP_EN: check and swallow the leading 0x80 sync byte,
// flagging sync_err on a mismatch. Without it every byte is presented and
// sync_err is tied low.
module usb_rx_bit_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int CNT_BITS     = 4
) (
  input logic                 clk,
  input logic                 rst,
  usb_rx_bit_decoder_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_EOP  = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [CNT_BITS-1:0] SAMPLE_PHASE = CNT_BITS'(SAMPLE_POINT);
  localparam logic [CNT_BITS-1:0] LAST_PHASE   = CNT_BITS'(CLKS_PER_BIT - 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_BITS-1:0] phase_q, phase_d;
  logic                dp_prev_q, dp_prev_d;
  logic                prev_level_q, prev_level_d;
  logic [2:0]          ones_cnt_q, ones_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [1:0]          se0_cnt_q, se0_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          rx_byte_q, rx_byte_d;
  logic                rx_byte_valid_q, rx_byte_valid_d;
  logic                eop_q, eop_d;
  logic                stuff_err_q, stuff_err_d;
`ifdef RX_SYNC_STRIP_EN
  logic                first_byte_q, first_byte_d;
  logic                sync_err_q, sync_err_d;
`endif

  logic       dp_edge;
  logic       line_se0;
  logic       line_j;
  logic       line_k;
  logic       sample;
  logic       bit_val;
  logic [7:0] shift_next;
  logic [3:0] bit_cnt_next;

  assign dp_edge      = bus.d_plus_sync != dp_prev_q;
  assign line_se0     = !bus.d_plus_sync && !bus.d_minus_sync;
  assign line_j       = bus.d_plus_sync && !bus.d_minus_sync;
  assign line_k       = !bus.d_plus_sync && bus.d_minus_sync;
  // A resync edge suppresses the sample that would otherwise fire this cycle
  assign sample       = (state_q != ST_IDLE) && !dp_edge && (phase_q == SAMPLE_PHASE);
  // NRZI: no transition means a 1
  assign bit_val      = bus.d_plus_sync == prev_level_q;
  assign shift_next   = {bit_val, shift_q[7:1]};
  assign bit_cnt_next = bit_cnt_q + 4'd1;

  // Bit-period phase counter, restarted by any D+ transition
  always_comb begin
    dp_prev_d = bus.d_plus_sync;
    phase_d   = phase_q;
    if (state_q == ST_IDLE || dp_edge) begin
      phase_d = '0;
    end else if (phase_q == LAST_PHASE) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 1'b1;
    end
  end

  // Receive state machine: decoding, destuffing, byte assembly and EOP/error tracking
  always_comb begin
    state_d         = state_q;
    prev_level_d    = prev_level_q;
    ones_cnt_d      = ones_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    se0_cnt_d       = se0_cnt_q;
    shift_d         = shift_q;
    rx_byte_d       = rx_byte_q;
    rx_byte_valid_d = 1'b0;
    eop_d           = 1'b0;
    stuff_err_d     = 1'b0;
`ifdef RX_SYNC_STRIP_EN
    first_byte_d    = first_byte_q;
    sync_err_d      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_enable && dp_prev_q && !bus.d_plus_sync && bus.d_minus_sync) begin
          state_d      = ST_RECV;
          prev_level_d = 1'b1;
          ones_cnt_d   = 3'd0;
          bit_cnt_d    = 4'd0;
          se0_cnt_d    = 2'd0;
`ifdef RX_SYNC_STRIP_EN
          first_byte_d = 1'b1;
`endif
        end
      end

      ST_RECV: begin
        if (sample) begin
          if (line_se0) begin
            se0_cnt_d = se0_cnt_q + 2'd1;
            if (se0_cnt_q == 2'd1) begin
              state_d   = ST_EOP;
              se0_cnt_d = 2'd0;
            end
          end else begin
            se0_cnt_d    = 2'd0;
            prev_level_d = bus.d_plus_sync;
            if (ones_cnt_q == 3'd6) begin
              ones_cnt_d = 3'd0;
              if (bit_val) begin
                stuff_err_d = 1'b1;
                state_d     = ST_ERR;
              end
            end else begin
              shift_d    = shift_next;
              ones_cnt_d = bit_val ? ones_cnt_q + 3'd1 : 3'd0;
              if (bit_cnt_next == 4'd8) begin
                bit_cnt_d = 4'd0;
`ifdef RX_SYNC_STRIP_EN
                if (first_byte_q) begin
                  first_byte_d = 1'b0;
                  if (shift_next != 8'h80) begin
                    sync_err_d = 1'b1;
                    state_d    = ST_ERR;
                  end
                end else begin
                  rx_byte_d       = shift_next;
                  rx_byte_valid_d = 1'b1;
                end
`else
                rx_byte_d       = shift_next;
                rx_byte_valid_d = 1'b1;
`endif
              end else begin
                bit_cnt_d = bit_cnt_next;
              end
            end
          end
        end
      end

      ST_EOP: begin
        if (sample) begin
          if (line_j) begin
            eop_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (line_k) begin
            state_d   = ST_ERR;
            se0_cnt_d = 2'd0;
          end
        end
      end

      default: begin
        if (sample) begin
          if (line_se0) begin
            se0_cnt_d = (se0_cnt_q == 2'd2) ? 2'd2 : se0_cnt_q + 2'd1;
          end else if (line_j && se0_cnt_q == 2'd2) begin
            state_d = ST_IDLE;
          end else begin
            se0_cnt_d = 2'd0;
          end
        end
      end
    endcase

    if (!bus.rx_enable) begin
      state_d         = ST_IDLE;
      rx_byte_d       = rx_byte_q;
      rx_byte_valid_d = 1'b0;
      eop_d           = 1'b0;
      stuff_err_d     = 1'b0;
`ifdef RX_SYNC_STRIP_EN
      sync_err_d      = 1'b0;
`endif
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      phase_q         <= '0;
      dp_prev_q       <= 1'b0;
      prev_level_q    <= 1'b1;
      ones_cnt_q      <= 3'd0;
      bit_cnt_q       <= 4'd0;
      se0_cnt_q       <= 2'd0;
      shift_q         <= 8'h00;
      rx_byte_q       <= 8'h00;
      rx_byte_valid_q <= 1'b0;
      eop_q           <= 1'b0;
      stuff_err_q     <= 1'b0;
`ifdef RX_SYNC_STRIP_EN
      first_byte_q    <= 1'b0;
      sync_err_q      <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      dp_prev_q       <= dp_prev_d;
      prev_level_q    <= prev_level_d;
      ones_cnt_q      <= ones_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      se0_cnt_q       <= se0_cnt_d;
      shift_q         <= shift_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      eop_q           <= eop_d;
      stuff_err_q     <= stuff_err_d;
`ifdef RX_SYNC_STRIP_EN
      first_byte_q    <= first_byte_d;
      sync_err_q      <= sync_err_d;
`endif
    end
  end

  assign bus.rx_byte       = rx_byte_q;
  assign bus.rx_byte_valid = rx_byte_valid_q;
  assign bus.rx_active     = state_q != ST_IDLE;
  assign bus.eop           = eop_q;
  assign bus.stuff_err     = stuff_err_q;
`ifdef RX_SYNC_STRIP_EN
  assign bus.sync_err      = sync_err_q;
`else
  assign bus.sync_err      = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Testbench for usb_rx_bit_decoder: table-driven packets, hand-written corner
// sequences (stuff error, EOP timing, enable drop, mid-packet reset) and random
// packets compared against an expected byte stream built from the payload.
module tb_usb_rx_bit_decoder;

  logic clk = 1'b0;
  logic rst;

  usb_rx_bit_decoder_if bus();

  usb_rx_bit_decoder #(
    .CLKS_PER_BIT(8),
    .SAMPLE_POINT(3),
    .CNT_BITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef RX_SYNC_STRIP_EN
  localparam bit SYNC_STRIPPED = 1'b1;
`else
  localparam bit SYNC_STRIPPED = 1'b0;
`endif

  // One line symbol: D+/D- levels held for len clocks
  typedef struct {
    logic dp;
    logic dm;
    int   len;
  } sym_t;

  // One table vector: payload bytes, bit-period pattern and expected results
  // (expBytes lists the sync byte first, then the payload, LSB byte first)
  typedef struct {
    logic [31:0] payload;
    int          nBytes;
    int          perA;
    int          perB;
    logic [39:0] expBytes;
    int          expCount;
    int          expEop;
    int          expStuff;
  } vec_t;

  int compared = 0;
  int mismatched = 0;

  sym_t       line[$];
  logic [7:0] expQ[$];
  logic [7:0] gotBytes[$];
  int         eopSeen, stuffSeen, syncSeen;

  int   bitIdx, perA, perB, onesRun;
  logic level;

  // Collect every strobe the decoder produces while out of reset
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.rx_byte_valid) gotBytes.push_back(bus.rx_byte);
      if (bus.eop) eopSeen++;
      if (bus.stuff_err) stuffSeen++;
      if (bus.sync_err) syncSeen++;
    end
  end

  // Single comparison with failure report
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Compare the collected byte stream against expQ
  task automatic checkBytes(input string name);
    checkOutput({name, "_count"}, gotBytes.size(), expQ.size());
    foreach (expQ[i])
      checkOutput($sformatf("%s_byte%0d", name, i),
                  (i < gotBytes.size()) ? {24'd0, gotBytes[i]} : 32'hFFFF_FFFF,
                  {24'd0, expQ[i]});
  endtask

  // All outputs must be at their reset values
  task automatic checkReset(input string name);
    checkOutput({name, "_rx_byte"}, {24'd0, bus.rx_byte}, 32'h0);
    checkOutput({name, "_valid"}, {31'd0, bus.rx_byte_valid}, 32'h0);
    checkOutput({name, "_active"}, {31'd0, bus.rx_active}, 32'h0);
    checkOutput({name, "_eop"}, {31'd0, bus.eop}, 32'h0);
    checkOutput({name, "_stuff_err"}, {31'd0, bus.stuff_err}, 32'h0);
    checkOutput({name, "_sync_err"}, {31'd0, bus.sync_err}, 32'h0);
  endtask

  task automatic clearMonitor();
    gotBytes.delete();
    expQ.delete();
    eopSeen = 0;
    stuffSeen = 0;
    syncSeen = 0;
  endtask

  // Bit periods alternate between perA and perB
  function automatic int nextPeriod();
    bitIdx++;
    return (bitIdx % 2 == 1) ? perA : perB;
  endfunction

  // Begin a fresh packet: idle J, line level J, stuffing run cleared
  task automatic startPacket(input int pa, input int pb);
    line.delete();
    perA = pa;
    perB = pb;
    bitIdx = 0;
    level = 1'b1;
    onesRun = 0;
    line.push_back('{1'b1, 1'b0, 6});
  endtask

  // NRZI-encode one data bit, inserting a stuffed zero after six ones when asked
  task automatic pushBit(input bit b, input bit doStuff);
    if (!b) level = ~level;
    line.push_back('{level, ~level, nextPeriod()});
    onesRun = b ? onesRun + 1 : 0;
    if (doStuff && onesRun == 6) begin
      level = ~level;
      line.push_back('{level, ~level, nextPeriod()});
      onesRun = 0;
    end
  endtask

  task automatic pushByte(input logic [7:0] v, input bit doStuff);
    for (int i = 0; i < 8; i++) pushBit(v[i], doStuff);
  endtask

  // SE0 for two bits, J for one bit, then idle J
  task automatic pushEop(input bit withJ);
    line.push_back('{1'b0, 1'b0, nextPeriod()});
    line.push_back('{1'b0, 1'b0, nextPeriod()});
    if (withJ) begin
      line.push_back('{1'b1, 1'b0, nextPeriod()});
      line.push_back('{1'b1, 1'b0, 6});
    end
    level = 1'b1;
    onesRun = 0;
  endtask

  // Play the symbol queue onto the line, changing levels on the falling edge
  task automatic applyStimulus();
    foreach (line[i]) begin
      bus.d_plus_sync = line[i].dp;
      bus.d_minus_sync = line[i].dm;
      repeat (line[i].len) @(negedge clk);
    end
    line.delete();
  endtask

  vec_t vecs[6];

  initial begin
    vec_t v;
    int   n, p;
    logic [7:0] rb;
    bit   seen;

    // Vector table: sync + payload, expected bytes include the sync byte first
    vecs[0] = '{32'h0000_00A5, 1, 8, 8, 40'h00_0000_A580, 2, 1, 0};
    vecs[1] = '{32'h0000_FFFF, 2, 8, 8, 40'h00_00FF_FF80, 3, 1, 0};
    vecs[2] = '{32'h0000_003C, 1, 9, 7, 40'h00_0000_3C80, 2, 1, 0};
    vecs[3] = '{32'h0000_005A, 1, 7, 9, 40'h00_0000_5A80, 2, 1, 0};
    vecs[4] = '{32'h00C3_7E00, 3, 8, 8, 40'h00_C37E_0080, 4, 1, 0};
    vecs[5] = '{32'h0000_7FFE, 2, 7, 9, 40'h00_007F_FE80, 3, 1, 0};

    rst = 1'b1;
    bus.rx_enable = 1'b0;
    bus.d_plus_sync = 1'b1;
    bus.d_minus_sync = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;
    bus.rx_enable = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven packets
    for (int t = 0; t < 6; t++) begin
      v = vecs[t];
      clearMonitor();
      for (int i = 0; i < v.expCount; i++)
        if (!(i == 0 && SYNC_STRIPPED)) expQ.push_back(v.expBytes[8*i +: 8]);
      startPacket(v.perA, v.perB);
      pushByte(8'h80, 1'b1);
      for (int i = 0; i < v.nBytes; i++) pushByte(v.payload[8*i +: 8], 1'b1);
      pushEop(1'b1);
      applyStimulus();
      repeat (10) @(negedge clk);
      checkBytes($sformatf("vec%0d", t));
      checkOutput($sformatf("vec%0d_eop", t), eopSeen, v.expEop);
      checkOutput($sformatf("vec%0d_stuff", t), stuffSeen, v.expStuff);
      checkOutput($sformatf("vec%0d_sync", t), syncSeen, 0);
      checkOutput($sformatf("vec%0d_active", t), {31'd0, bus.rx_active}, 0);
    end

    // 0x3C then EOP: watch the eop strobe and rx_active drop
    clearMonitor();
    if (!SYNC_STRIPPED) expQ.push_back(8'h80);
    expQ.push_back(8'h3C);
    startPacket(8, 8);
    pushByte(8'h80, 1'b1);
    pushByte(8'h3C, 1'b1);
    pushEop(1'b0);
    applyStimulus();
    bus.d_plus_sync = 1'b1;
    bus.d_minus_sync = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.eop) seen = 1'b1;
    end
    checkOutput("eop_seen", {31'd0, seen}, 1);
    @(negedge clk);
    checkOutput("eop_one_cycle", {31'd0, bus.eop}, 0);
    checkOutput("eop_active_low", {31'd0, bus.rx_active}, 0);
    repeat (10) @(negedge clk);
    checkBytes("eop3c");
    checkOutput("eop3c_eop_count", eopSeen, 1);

    // Seven ones after sync with no stuffed zero: stuff error, then SE0,SE0,J exit
    clearMonitor();
    if (!SYNC_STRIPPED) expQ.push_back(8'h80);
    startPacket(8, 8);
    pushByte(8'h80, 1'b1);
    for (int i = 0; i < 7; i++) pushBit(1'b1, 1'b0);
    applyStimulus();
    repeat (4) @(negedge clk);
    checkOutput("stuff_err_count", stuffSeen, 1);
    checkOutput("stuff_active_held", {31'd0, bus.rx_active}, 1);
    pushEop(1'b1);
    applyStimulus();
    repeat (4) @(negedge clk);
    checkOutput("stuff_active_released", {31'd0, bus.rx_active}, 0);
    checkOutput("stuff_no_eop", eopSeen, 0);
    checkOutput("stuff_err_once", stuffSeen, 1);
    checkBytes("stuff");

    // Dropping rx_enable mid-packet returns to idle without strobes
    clearMonitor();
    if (!SYNC_STRIPPED) expQ.push_back(8'h80);
    startPacket(8, 8);
    pushByte(8'h80, 1'b1);
    pushBit(1'b1, 1'b1);
    pushBit(1'b0, 1'b1);
    pushBit(1'b1, 1'b1);
    applyStimulus();
    bus.rx_enable = 1'b0;
    bus.d_plus_sync = 1'b1;
    bus.d_minus_sync = 1'b0;
    @(negedge clk);
    checkOutput("disable_active", {31'd0, bus.rx_active}, 0);
    repeat (20) @(negedge clk);
    bus.rx_enable = 1'b1;
    repeat (4) @(negedge clk);
    checkBytes("disable");
    checkOutput("disable_no_eop", eopSeen, 0);

    // Reset mid-byte, then a clean 0x80,0x11 packet
    clearMonitor();
    startPacket(8, 8);
    pushByte(8'h80, 1'b1);
    pushBit(1'b1, 1'b1);
    pushBit(1'b0, 1'b1);
    pushBit(1'b1, 1'b1);
    pushBit(1'b1, 1'b1);
    applyStimulus();
    rst = 1'b1;
    bus.d_plus_sync = 1'b1;
    bus.d_minus_sync = 1'b0;
    @(negedge clk);
    checkReset("midreset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    clearMonitor();
    if (!SYNC_STRIPPED) expQ.push_back(8'h80);
    expQ.push_back(8'h11);
    startPacket(8, 8);
    pushByte(8'h80, 1'b1);
    pushByte(8'h11, 1'b1);
    pushEop(1'b1);
    applyStimulus();
    repeat (10) @(negedge clk);
    checkBytes("after_reset");
    checkOutput("after_reset_eop", eopSeen, 1);

    // Random packets: the decoded stream must be the sync byte and the payload
    for (int r = 0; r < 20; r++) begin
      clearMonitor();
      n = $urandom_range(1, 4);
      p = $urandom_range(0, 2);
      if (p == 0) startPacket(8, 8);
      else if (p == 1) startPacket(7, 9);
      else startPacket(9, 7);
      if (!SYNC_STRIPPED) expQ.push_back(8'h80);
      pushByte(8'h80, 1'b1);
      for (int i = 0; i < n; i++) begin
        rb = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) rb = 8'hFF;
        expQ.push_back(rb);
        pushByte(rb, 1'b1);
      end
      pushEop(1'b1);
      applyStimulus();
      repeat (10) @(negedge clk);
      checkBytes($sformatf("rand%0d", r));
      checkOutput($sformatf("rand%0d_eop", r), eopSeen, 1);
      checkOutput($sformatf("rand%0d_stuff", r), stuffSeen, 0);
      checkOutput($sformatf("rand%0d_sync", r), syncSeen, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
